// File: rtl/mem_stage_if.sv
// Data-memory handshake between the Y86 memory stage (master) and the data memory (slave).
// Widths are global defines shared by every pipeline stage.
`ifndef WORD
`define WORD 32
`endif
`ifndef NIBBLE
`define NIBBLE 4
`endif

interface mem_stage_if;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [`WORD-1:0]  mem_addr_o;
   logic [`WORD-1:0]  mem_wdata_o;
   logic              mem_ack_i;
   logic [`WORD-1:0]  mem_rdata_i;
   logic              mem_err_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i, mem_err_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i, mem_err_i
   );
endinterface

// File: rtl/mem_stage.sv
// Y86 memory stage: M pipeline register plus a wait-state tolerant data-memory access.
// While an access is pending the stage requests a stall and shows a bubble to W.
`ifndef WORD
`define WORD 32
`endif
`ifndef NIBBLE
`define NIBBLE 4
`endif

module mem_stage (
   input  logic                clk,
   input  logic                rst,
   input  logic                M_stall_i,
   input  logic                M_bubble_i,
   input  logic [`NIBBLE-1:0]  E_icode_i,
   input  logic [`NIBBLE-1:0]  E_stat_i,
   input  logic                e_Cnd_i,
   input  logic [`WORD-1:0]    e_valE_i,
   input  logic [`WORD-1:0]    E_valA_i,
   input  logic [`NIBBLE-1:0]  e_dstE_i,
   input  logic [`NIBBLE-1:0]  E_dstM_i,
   mem_stage_if.master         mem,
   output logic [`NIBBLE-1:0]  M_icode_o,
   output logic [`WORD-1:0]    M_valE_o,
   output logic [`NIBBLE-1:0]  M_dstE_o,
   output logic [`NIBBLE-1:0]  M_dstM_o,
   output logic [`WORD-1:0]    m_valM_o,
   output logic [`NIBBLE-1:0]  m_stat_o,
   output logic                M_Cnd_o,
   output logic [`WORD-1:0]    M_valA_o,
   output logic                m_busy_o
);

   localparam logic [`NIBBLE-1:0] INOP    = 4'h1;
   localparam logic [`NIBBLE-1:0] IRMMOVL = 4'h4;
   localparam logic [`NIBBLE-1:0] IMRMOVL = 4'h5;
   localparam logic [`NIBBLE-1:0] ICALL   = 4'h8;
   localparam logic [`NIBBLE-1:0] IRET    = 4'h9;
   localparam logic [`NIBBLE-1:0] IPUSHL  = 4'hA;
   localparam logic [`NIBBLE-1:0] IPOPL   = 4'hB;
   localparam logic [`NIBBLE-1:0] RNONE   = 4'hF;
   localparam logic [`NIBBLE-1:0] SAOK    = 4'h1;
   localparam logic [`NIBBLE-1:0] SADR    = 4'h3;

   typedef enum logic {ACC, DONE} state_t;

   state_t              state;
   logic [`NIBBLE-1:0]  m_icode, m_stat, m_dstE, m_dstM;
   logic                m_cnd;
   logic [`WORD-1:0]    m_valE, m_valA, valM_q;
   logic                err_q;
   logic                is_write, is_read, memop, hold, acked;

   always_comb begin
      is_write = 1'b0;
      is_read  = 1'b0;
      case (m_icode)
         IRMMOVL, ICALL, IPUSHL: is_write = 1'b1;
         IMRMOVL, IRET, IPOPL:   is_read  = 1'b1;
         default: ;
      endcase
   end

   assign memop    = (m_stat == SAOK) & (is_write | is_read);
   assign acked    = memop & (state == ACC) & mem.mem_ack_i;
   assign m_busy_o = memop & (state == ACC) & ~mem.mem_ack_i;
   assign hold     = M_stall_i | m_busy_o;

   // Request is derived from M contents, so an async reset drops it immediately.
   assign mem.mem_req_o   = memop & (state == ACC);
   assign mem.mem_we_o    = mem.mem_req_o & is_write;
   assign mem.mem_addr_o  = (m_icode == IRET || m_icode == IPOPL) ? m_valA : m_valE;
   assign mem.mem_wdata_o = m_valA;

   // A fresh M load always restarts the access; a completion under external
   // stall parks the result in valM_q so the access is never repeated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_icode <= INOP;
         m_stat  <= SAOK;
         m_cnd   <= 1'b0;
         m_valE  <= '0;
         m_valA  <= '0;
         m_dstE  <= RNONE;
         m_dstM  <= RNONE;
         state   <= ACC;
         valM_q  <= '0;
         err_q   <= 1'b0;
      end else if (!hold) begin
         if (M_bubble_i) begin
            m_icode <= INOP;
            m_stat  <= SAOK;
            m_cnd   <= 1'b0;
            m_valE  <= '0;
            m_valA  <= '0;
            m_dstE  <= RNONE;
            m_dstM  <= RNONE;
         end else begin
            m_icode <= E_icode_i;
            m_stat  <= E_stat_i;
            m_cnd   <= e_Cnd_i;
            m_valE  <= e_valE_i;
            m_valA  <= E_valA_i;
            m_dstE  <= e_dstE_i;
            m_dstM  <= E_dstM_i;
         end
         state  <= ACC;
         valM_q <= '0;
         err_q  <= 1'b0;
      end else if (acked) begin
         valM_q <= (is_read && !mem.mem_err_i) ? mem.mem_rdata_i : '0;
         err_q  <= mem.mem_err_i;
         state  <= DONE;
      end
   end

   always_comb begin
      m_valM_o = '0;
      if (acked && is_read && !mem.mem_err_i)
         m_valM_o = mem.mem_rdata_i;
      else if (state == DONE)
         m_valM_o = valM_q;
   end

   always_comb begin
      m_stat_o = SAOK;
      if (m_busy_o)
         m_stat_o = SAOK;
      else if (m_stat != SAOK)
         m_stat_o = m_stat;
      else if (memop && ((state == DONE && err_q) || (acked && mem.mem_err_i)))
         m_stat_o = SADR;
   end

   assign M_icode_o = m_busy_o ? INOP  : m_icode;
   assign M_dstE_o  = m_busy_o ? RNONE : m_dstE;
   assign M_dstM_o  = m_busy_o ? RNONE : m_dstM;
   assign M_valE_o  = m_valE;
   assign M_Cnd_o   = m_cnd;
   assign M_valA_o  = m_valA;

endmodule
